// File: rtl/button_defs.sv
// Shared definitions for the button/LED front end: FSM state codes and the
// 100 ms tick constant that the debouncer and the blink driver both default to.
package button_defs;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ON   = 2'b01;
  localparam logic [1:0] OFF  = 2'b10;

  localparam logic [23:0] TICKS_100MS = 24'd10_000_000;

endpackage

// File: rtl/led_blink_driver_dwell_timer.sv
// Dwell counter: counts up from 0 while enabled and holds at a runtime-selected
// limit, flagging terminal count so the owner can change state and clear it.
module dwell_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !done) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = (count_reg == limit);

endmodule

// File: rtl/led_blink_driver.sv
// Turns 1-cycle event pulses into visible LED blinks (ON then a guaranteed dark
// gap), queueing pulses that arrive mid-blink in a saturating pending counter.
module led_blink_driver
  import button_defs::*;
#(
  parameter int ON_CYCLES  = int'(TICKS_100MS),
  parameter int OFF_CYCLES = int'(TICKS_100MS),
  parameter int CNT_W      = 24,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  ON_LIMIT  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LIMIT = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic [1:0]        state_reg, state_next;
  logic              led_reg, led_next;
  logic              busy_reg, busy_next;
  logic [PEND_W-1:0] pending_reg, pending_next;
  logic              overflow_reg, overflow_next;

  logic              timer_en, timer_clear, timer_done;
  logic [CNT_W-1:0]  timer_limit;
  logic              pend_inc, pend_dec;

  // The counter runs only in ON/OFF and restarts from 0 at every phase change.
  assign timer_en    = (state_reg == ON) || (state_reg == OFF);
  assign timer_clear = !timer_en || timer_done;
  assign timer_limit = (state_reg == ON) ? ON_LIMIT : OFF_LIMIT;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      led_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      led_reg      <= led_next;
      busy_reg     <= busy_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pulse_in || (pending_reg != '0)) state_next = ON;
      ON:      if (timer_done) state_next = OFF;
      OFF:     if (timer_done) state_next = (pending_reg != '0) ? ON : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pulse and a blink start in the same cycle cancel, leaving pending as is.
  always_comb begin
    pend_inc      = pulse_in && timer_en;
    pend_dec      = (pending_reg != '0) &&
                    (((state_reg == IDLE) && !pulse_in) ||
                     ((state_reg == OFF) && timer_done));
    pending_next  = pending_reg;
    overflow_next = overflow_reg;
    if (pend_inc && !pend_dec) begin
      if (pending_reg == PEND_MAX) overflow_next = 1'b1;
      else                         pending_next  = pending_reg + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pending_next = pending_reg - 1'b1;
    end
    led_next  = (state_next == ON);
    busy_next = (state_next == ON) || (state_next == OFF);
  end

  assign led_out  = led_reg;
  assign busy     = busy_reg;
  assign pending  = pending_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed per-cycle vectors for led_blink_driver (ON=4, OFF=3, PEND_W=2); the
// driver queues expected outputs and a separate monitor pops and compares them.
module tb_led_blink_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         idx;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  led_blink_driver #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .CNT_W      (3),
    .PEND_W     (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  function automatic string rep(input string s, input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  function automatic logic [1:0] dig(input string s, input int i);
    return 2'(int'(s[i]) - 48);
  endfunction

  // Each column holds one character per cycle; the expectation at index k is the
  // registered output after the clock edge that consumed inputs k.
  task automatic run_vec(input string tag, input string rst, input string pls,
                         input string led, input string bsy, input string pnd,
                         input string ovf);
    int   n;
    exp_t e;
    n = pls.len();
    if (rst.len() != n || led.len() != n || bsy.len() != n ||
        pnd.len() != n || ovf.len() != n) begin
      $display("FAIL %s: vector columns have unequal lengths", tag);
      $fatal(1, "bad vector table");
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset    = (dig(rst, i) != 2'd0);
      pulse_in = (dig(pls, i) != 2'd0);
      e.tag  = tag;
      e.idx  = i;
      e.led  = (dig(led, i) != 2'd0);
      e.busy = (dig(bsy, i) != 2'd0);
      e.pend = dig(pnd, i);
      e.ovf  = (dig(ovf, i) != 2'd0);
      sb_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if ({led_out, busy, pending, overflow} !== {mon_e.led, mon_e.busy, mon_e.pend, mon_e.ovf}) begin
        errors++;
        $display("FAIL %s[%0d]: got led=%b busy=%b pend=%0d ovf=%b, expected led=%b busy=%b pend=%0d ovf=%b",
                 mon_e.tag, mon_e.idx, led_out, busy, pending, overflow,
                 mon_e.led, mon_e.busy, mon_e.pend, mon_e.ovf);
      end else begin
        $display("  %s[%0d] led=%b busy=%b pend=%0d ovf=%b ok",
                 mon_e.tag, mon_e.idx, led_out, busy, pending, overflow);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    pulse_in = 1'b0;

    // reset held with pulse_in high: nothing may start
    run_vec("reset_hold", {"00", rep("1", 5)}, {"11", rep("0", 5)},
            rep("0", 7), rep("0", 7), rep("0", 7), rep("0", 7));

    // single pulse: 4 on, 3 off, idle
    run_vec("single", rep("1", 10), {"1", rep("0", 9)},
            {rep("1", 4), rep("0", 6)}, {rep("1", 7), rep("0", 3)},
            rep("0", 10), rep("0", 10));

    // pulses at t, t+2, t+3: three blinks, pending 2 -> 1 -> 0
    run_vec("three", rep("1", 23), {"1011", rep("0", 19)},
            {"1111000", "1111000", "1111", "00000"},
            {rep("1", 21), "00"},
            {"001", rep("2", 4), rep("1", 7), rep("0", 9)},
            rep("0", 23));

    // five back-to-back pulses: saturate at 3, overflow sticks, four blinks
    run_vec("saturate", rep("1", 30), {rep("1", 5), rep("0", 25)},
            {"1111000", "1111000", "1111000", "1111000", "00"},
            {rep("1", 28), "00"},
            {"0123333", rep("2", 7), rep("1", 7), rep("0", 9)},
            {"0000", rep("1", 26)});

    // reset clears overflow; pulse on last OFF cycle with pending=1 keeps it at 1
    run_vec("last_off_p1", {"0", rep("1", 23)}, {"011000001", rep("0", 15)},
            {"0", "1111000", "1111000", "1111", "00000"},
            {"0", rep("1", 21), "00"},
            {"00", rep("1", 13), rep("0", 9)},
            rep("0", 24));

    // pulse on last OFF cycle with pending=0: one dark idle cycle, then blink
    run_vec("last_off_p0", rep("1", 17), {"10000001", rep("0", 9)},
            {"1111", "0000", "1111", "00000"},
            {rep("1", 7), "0", rep("1", 7), "00"},
            {rep("0", 7), "1", rep("0", 9)},
            rep("0", 17));

    // reset in second ON cycle aborts blink and pending; fresh pulse gives full blink
    run_vec("mid_reset", {"110", rep("1", 9)}, {"1111", rep("0", 8)},
            {"11", "0", "1111", "00000"},
            {"11", "0", rep("1", 7), "00"},
            {"01", rep("0", 10)},
            rep("0", 12));

    @(negedge clk);
    pulse_in = 1'b0;
    for (int w = 0; w < 5 && sb_q.size() != 0; w++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
